sram_d_obi_arbiter: RTL and testbench

// - Two-master OBI arbiter feeding the SRAM wrapper's data port (sram_d_*). Sits directly upstream of it.
// - Master 0 is the core LSU; master 1 is the DMA/debug master. Round-robin arbitration; responses return in order.
// - Checks every request against the SRAM window. Out-of-window requests are accepted but never forwarded,
//   and get an error response. This replaces the SRAM wrapper's constant-0 illegal flag.

---
 rtl/sram_pkg.sv | 21 ++
 rtl/obi_rsp_fifo.sv | 66 ++++++
 rtl/sram_d_obi_arbiter.sv | 148 ++++++++++++++
 tb/tb_sram_d_obi_arbiter.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/sram_pkg.sv
// Shared definitions for the SRAM data-port arbiter: window defaults,
// the in-flight response tag and the window decode helper.
package sram_pkg;

    localparam logic [31:0] SRAM_BASE_ADDR_DEF = 32'h8000_0000;
    localparam logic [31:0] SRAM_END_ADDR_DEF  = 32'h8000_C000;

    // One tag per accepted request: who asked, and whether it missed the window.
    typedef struct packed {
        logic owner;
        logic err;
    } sram_rsp_tag_t;

    // Base is inclusive, limit is exclusive.
    function automatic logic addr_in_window(input logic [31:0] addr,
                                            input logic [31:0] base,
                                            input logic [31:0] lim);
        return (addr >= base) && (addr < lim);
    endfunction

endpackage

// File: rtl/obi_rsp_fifo.sv
// In-order tag FIFO that remembers owner/error of every accepted request
// until its response has been delivered.
module obi_rsp_fifo
    import sram_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          push_i,
    input  sram_rsp_tag_t push_tag_i,
    input  logic          pop_i,
    output logic          full_o,
    output logic          empty_o,
    output sram_rsp_tag_t head_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [PW-1:0] wptr_reg;
    logic [PW-1:0] rptr_reg;
    logic [PW:0]   count_reg;
    sram_rsp_tag_t mem_reg [DEPTH];

    logic push_ok;
    logic pop_ok;

    assign full_o  = (count_reg == (PW+1)'(DEPTH));
    assign empty_o = (count_reg == '0);
    assign head_o  = mem_reg[rptr_reg];
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    // Tag storage; entries are cleared on reset so a dropped flight leaves no residue.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_reg[i] <= '0;
            end
        end else if (push_ok) begin
            mem_reg[wptr_reg] <= push_tag_i;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wptr_reg  <= '0;
            rptr_reg  <= '0;
            count_reg <= '0;
        end else begin
            if (push_ok) begin
                wptr_reg <= wptr_reg + 1'b1;
            end
            if (pop_ok) begin
                rptr_reg <= rptr_reg + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/sram_d_obi_arbiter.sv
// Two-master round-robin OBI arbiter in front of the SRAM data port.
// Requests outside the SRAM window are absorbed here and answered with err.
module sram_d_obi_arbiter
    import sram_pkg::*;
#(
    parameter logic [31:0] SRAM_BASE_ADDR = SRAM_BASE_ADDR_DEF,
    parameter logic [31:0] SRAM_END_ADDR  = SRAM_END_ADDR_DEF,
    parameter int          FIFO_DEPTH     = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        m0_req_i,
    output logic        m0_gnt_o,
    input  logic [31:0] m0_addr_i,
    input  logic        m0_we_i,
    input  logic [3:0]  m0_be_i,
    input  logic [31:0] m0_wdata_i,
    output logic        m0_rvalid_o,
    output logic [31:0] m0_rdata_o,
    output logic        m0_err_o,
    input  logic        m1_req_i,
    output logic        m1_gnt_o,
    input  logic [31:0] m1_addr_i,
    input  logic        m1_we_i,
    input  logic [3:0]  m1_be_i,
    input  logic [31:0] m1_wdata_i,
    output logic        m1_rvalid_o,
    output logic [31:0] m1_rdata_o,
    output logic        m1_err_o,
    output logic        s_req_o,
    input  logic        s_gnt_i,
    output logic [31:0] s_addr_o,
    output logic        s_we_o,
    output logic [3:0]  s_be_o,
    output logic [31:0] s_wdata_o,
    input  logic        s_rvalid_i,
    input  logic [31:0] s_rdata_i
);

    logic [1:0]    req_v;
    logic [1:0]    legal_v;
    logic [1:0]    elig_v;
    logic [1:0]    gnt_v;
    logic [1:0]    rvalid_v;
    logic [31:0]   addr_v  [2];
    logic [31:0]   wdata_v [2];
    logic [3:0]    be_v    [2];
    logic [1:0]    we_v;

    logic          rr_last_reg;
    logic          just_rst_reg;
    logic          sel;
    logic          sel_legal;
    logic          any_elig;
    logic          hs;
    logic          fifo_full;
    logic          fifo_empty;
    logic          rsp_fire;
    logic [31:0]   rdata_fwd;
    sram_rsp_tag_t head;
    sram_rsp_tag_t push_tag;

    assign req_v      = {m1_req_i, m0_req_i};
    assign we_v       = {m1_we_i, m0_we_i};
    assign addr_v[0]  = m0_addr_i;
    assign addr_v[1]  = m1_addr_i;
    assign wdata_v[0] = m0_wdata_i;
    assign wdata_v[1] = m1_wdata_i;
    assign be_v[0]    = m0_be_i;
    assign be_v[1]    = m1_be_i;

    // Window decode and eligibility per master; nothing is eligible while in reset.
    for (genvar gi = 0; gi < 2; gi++) begin : g_master
        assign legal_v[gi] = addr_in_window(addr_v[gi], SRAM_BASE_ADDR, SRAM_END_ADDR);
        assign elig_v[gi]  = req_v[gi] && !fifo_full && !rst_i;
    end

    // Arbitration and request mux; illegal requests are granted locally without s_req_o.
    always_comb begin
        any_elig  = |elig_v;
        sel       = (&elig_v) ? ~rr_last_reg : elig_v[1];
        sel_legal = legal_v[sel];
        s_req_o   = any_elig && sel_legal;
        hs        = any_elig && (sel_legal ? s_gnt_i : 1'b1);
        gnt_v     = 2'b00;
        gnt_v[sel] = hs;
        s_addr_o  = s_req_o ? addr_v[sel]  : 32'h0;
        s_we_o    = s_req_o ? we_v[sel]    : 1'b0;
        s_be_o    = s_req_o ? be_v[sel]    : 4'h0;
        s_wdata_o = s_req_o ? wdata_v[sel] : 32'h0;
        push_tag.owner = sel;
        push_tag.err   = !sel_legal;
    end

    assign m0_gnt_o = gnt_v[0];
    assign m1_gnt_o = gnt_v[1];

    // Remember the last winner; reset to 1 so master 0 wins the first conflict.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rr_last_reg <= 1'b1;
        end else if (hs) begin
            rr_last_reg <= sel;
        end
    end

    obi_rsp_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_rsp_fifo (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .push_i     (hs),
        .push_tag_i (push_tag),
        .pop_i      (rsp_fire),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .head_o     (head)
    );

    // Response demux: error heads answer at once, legal heads wait for the SRAM.
    always_comb begin
        rsp_fire    = !fifo_empty && (head.err || s_rvalid_i);
        rdata_fwd   = (rsp_fire && !head.err) ? s_rdata_i : 32'h0;
        rvalid_v    = 2'b00;
        rvalid_v[head.owner] = rsp_fire;
    end

    assign m0_rvalid_o = rvalid_v[0];
    assign m1_rvalid_o = rvalid_v[1];
    assign m0_rdata_o  = rvalid_v[0] ? rdata_fwd : 32'h0;
    assign m1_rdata_o  = rvalid_v[1] ? rdata_fwd : 32'h0;
    assign m0_err_o    = rvalid_v[0] && head.err;
    assign m1_err_o    = rvalid_v[1] && head.err;

    // Marks the first cycle after reset, when a stale SRAM response may still arrive.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            just_rst_reg <= 1'b1;
        end else begin
            just_rst_reg <= 1'b0;
        end
    end

    // An SRAM response with no legal request waiting is a protocol violation.
    a_rvalid_expected: assert property (@(posedge clk_i) disable iff (rst_i)
        (s_rvalid_i && !just_rst_reg) |-> (!fifo_empty && !head.err));

endmodule

// File: tb/tb_sram_d_obi_arbiter.sv
// Scoreboard bench for the SRAM data-port arbiter with a 1-cycle SRAM model.
module tb_sram_d_obi_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        m0_req_i, m0_we_i, m1_req_i, m1_we_i;
    logic [31:0] m0_addr_i, m0_wdata_i, m1_addr_i, m1_wdata_i;
    logic [3:0]  m0_be_i, m1_be_i;
    logic        m0_gnt_o, m0_rvalid_o, m0_err_o, m1_gnt_o, m1_rvalid_o, m1_err_o;
    logic [31:0] m0_rdata_o, m1_rdata_o;
    logic        s_req_o, s_gnt_i, s_we_o, s_rvalid_i;
    logic [31:0] s_addr_o, s_wdata_o, s_rdata_i;
    logic [3:0]  s_be_o;

    always #5 clk_i = ~clk_i;

    sram_d_obi_arbiter dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .m0_req_i(m0_req_i), .m0_gnt_o(m0_gnt_o), .m0_addr_i(m0_addr_i), .m0_we_i(m0_we_i),
        .m0_be_i(m0_be_i), .m0_wdata_i(m0_wdata_i), .m0_rvalid_o(m0_rvalid_o),
        .m0_rdata_o(m0_rdata_o), .m0_err_o(m0_err_o),
        .m1_req_i(m1_req_i), .m1_gnt_o(m1_gnt_o), .m1_addr_i(m1_addr_i), .m1_we_i(m1_we_i),
        .m1_be_i(m1_be_i), .m1_wdata_i(m1_wdata_i), .m1_rvalid_o(m1_rvalid_o),
        .m1_rdata_o(m1_rdata_o), .m1_err_o(m1_err_o),
        .s_req_o(s_req_o), .s_gnt_i(s_gnt_i), .s_addr_o(s_addr_o), .s_we_o(s_we_o),
        .s_be_o(s_be_o), .s_wdata_o(s_wdata_o), .s_rvalid_i(s_rvalid_i), .s_rdata_i(s_rdata_i)
    );

    typedef struct {
        bit          owner;
        bit          err;
        logic [31:0] data;
        logic [31:0] addr;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] pend_q[$];
    logic [31:0] mem [logic [31:0]];
    bit          rr_m;
    bit          hold;
    bit          last_g0, last_g1;
    int          n_checks = 0;
    int          n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h @%0t", tag, got, exp, $time);
    endtask

    function automatic bit in_window(input logic [31:0] a);
        return (a >= 32'h8000_0000) && (a < 32'h8000_C000);
    endfunction

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        logic [31:0] w;
        w = {a[31:2], 2'b00};
        if (mem.exists(w)) return mem[w];
        return {w[15:0], ~w[15:0]};
    endfunction

    // One clock: check combinational outputs at negedge against the model, then
    // advance the SRAM model and drive its response 1 ns after the next posedge.
    task automatic tick();
        bit          e0, e1, lg, exp_sreq, exp_hs, exp_rv, win, has_win, we;
        logic [31:0] a, wd, rd;
        logic [3:0]  be;
        exp_t        e;
        @(negedge clk_i);
        e0 = m0_req_i && (exp_q.size() < 2);
        e1 = m1_req_i && (exp_q.size() < 2);
        has_win = e0 || e1;
        win = (e0 && e1) ? !rr_m : e1;
        a  = win ? m1_addr_i  : m0_addr_i;
        we = win ? m1_we_i    : m0_we_i;
        be = win ? m1_be_i    : m0_be_i;
        wd = win ? m1_wdata_i : m0_wdata_i;
        lg = in_window(a);
        exp_sreq = has_win && lg;
        exp_hs   = has_win && (!lg || s_gnt_i);
        check("s_req", 32'(s_req_o), 32'(exp_sreq));
        check("gnt0", 32'(m0_gnt_o), 32'(exp_hs && !win));
        check("gnt1", 32'(m1_gnt_o), 32'(exp_hs && win));
        if (exp_sreq) begin
            check("s_addr", s_addr_o, a);
            check("s_we_be", {27'h0, s_we_o, s_be_o}, {27'h0, we, be});
            check("s_wdata", s_wdata_o, wd);
        end
        exp_rv = (exp_q.size() > 0) && (exp_q[0].err || s_rvalid_i);
        e.owner = (exp_q.size() > 0) ? exp_q[0].owner : 1'b0;
        check("rvalid0", 32'(m0_rvalid_o), 32'(exp_rv && !e.owner));
        check("rvalid1", 32'(m1_rvalid_o), 32'(exp_rv && e.owner));
        if (exp_rv) begin
            e = exp_q.pop_front();
            check(e.owner ? "rdata1" : "rdata0", e.owner ? m1_rdata_o : m0_rdata_o, e.data);
            check(e.owner ? "err1" : "err0", 32'(e.owner ? m1_err_o : m0_err_o), 32'(e.err));
            $display("rsp m%0d addr=%h err=%0d data=%h", e.owner, e.addr, e.err, e.data);
        end
        last_g0 = exp_hs && !win;
        last_g1 = exp_hs && win;
        if (exp_hs) begin
            e.owner = win;
            e.err   = !lg;
            e.addr  = a;
            e.data  = (!lg || we) ? 32'h0 : mem_rd(a);
            exp_q.push_back(e);
            rr_m = win;
        end
        if (s_req_o && s_gnt_i) begin
            rd = s_we_o ? 32'h0 : mem_rd(s_addr_o);
            if (s_we_o) begin
                logic [31:0] w;
                w = mem_rd(s_addr_o);
                for (int b = 0; b < 4; b++) if (s_be_o[b]) w[8*b +: 8] = s_wdata_o[8*b +: 8];
                mem[{s_addr_o[31:2], 2'b00}] = w;
            end
            pend_q.push_back(rd);
        end
        @(posedge clk_i);
        #1;
        if (!hold && pend_q.size() > 0) begin
            s_rvalid_i = 1'b1;
            s_rdata_i  = pend_q.pop_front();
        end else begin
            s_rvalid_i = 1'b0;
            s_rdata_i  = 32'h0;
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_outs"}, {26'h0, s_req_o, m0_gnt_o, m1_gnt_o, m0_rvalid_o, m1_rvalid_o,
               m0_err_o | m1_err_o}, 32'h0);
        check({tag, "_bus"}, s_addr_o | s_wdata_o | m0_rdata_o | m1_rdata_o, 32'h0);
    endtask

    task automatic model_reset();
        exp_q.delete();
        pend_q.delete();
        rr_m = 1'b1;
        hold = 1'b0;
        s_rvalid_i = 1'b0;
        s_rdata_i  = 32'h0;
    endtask

    initial begin
        rst_i = 1'b1;
        m0_req_i = 1'b1; m0_addr_i = 32'h8000_0000; m0_we_i = 1'b0; m0_be_i = 4'hF; m0_wdata_i = '0;
        m1_req_i = 1'b1; m1_addr_i = 32'h8000_0004; m1_we_i = 1'b0; m1_be_i = 4'hF; m1_wdata_i = '0;
        s_gnt_i = 1'b1;
        model_reset();
        #3;
        check_all_zero("reset");
        @(posedge clk_i); @(posedge clk_i); #1;
        rst_i = 1'b0; m0_req_i = 1'b0; m1_req_i = 1'b0;

        // Single m0 read.
        m0_req_i = 1'b1; m0_addr_i = 32'h8000_0010;
        tick();
        m0_req_i = 1'b0;
        tick();

        // Both masters continuously for 6 cycles: m0 reads, m1 writes.
        m0_req_i = 1'b1; m0_addr_i = 32'h8000_0100; m0_we_i = 1'b0;
        m1_req_i = 1'b1; m1_addr_i = 32'h8000_0200; m1_we_i = 1'b1; m1_wdata_i = 32'hCAFE_0000;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (last_g0) m0_addr_i += 32'h4;
            if (last_g1) begin m1_addr_i += 32'h4; m1_wdata_i += 32'h1; end
        end
        m0_req_i = 1'b0; m1_req_i = 1'b0;
        tick(); tick();

        // Read back one of the m1 writes with a partial byte-enable write first.
        m0_req_i = 1'b1; m0_addr_i = 32'h8000_0200; m0_we_i = 1'b1; m0_be_i = 4'b0101;
        m0_wdata_i = 32'h1122_3344;
        tick();
        m0_we_i = 1'b0; m0_be_i = 4'hF;
        tick();
        m0_req_i = 1'b0;
        tick();

        // m1 illegal write at window end, then legal read of the last word.
        m1_req_i = 1'b1; m1_addr_i = 32'h8000_C000; m1_we_i = 1'b1; m1_wdata_i = 32'hDEAD_BEEF;
        tick();
        m1_addr_i = 32'h8000_BFFC; m1_we_i = 1'b0;
        tick();
        m1_req_i = 1'b0;
        tick(); tick();

        // Interleaved m0 illegal / m1 legal, plus one below-window address.
        m0_req_i = 1'b1; m0_addr_i = 32'h0000_0100; m0_we_i = 1'b0;
        m1_req_i = 1'b1; m1_addr_i = 32'h8000_0004; m1_we_i = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (i == 4) m0_addr_i = 32'h7FFF_FFFC;
            tick();
        end
        m0_req_i = 1'b0; m1_req_i = 1'b0;
        tick(); tick();

        // SRAM withholds grant for 3 cycles.
        m0_req_i = 1'b1; m0_addr_i = 32'h8000_0040; s_gnt_i = 1'b0;
        tick(); tick(); tick();
        s_gnt_i = 1'b1;
        tick();
        m0_req_i = 1'b0;
        tick();

        // Fill the FIFO with held responses, observe full, then reset mid-flight.
        hold = 1'b1;
        m0_req_i = 1'b1; m0_addr_i = 32'h8000_0020;
        m1_req_i = 1'b1; m1_addr_i = 32'h8000_0024;
        tick(); tick(); tick();
        #2;
        rst_i = 1'b1;
        #1;
        check_all_zero("async_rst");
        model_reset();
        @(posedge clk_i); @(posedge clk_i); #1;
        rst_i = 1'b0;
        tick();
        m0_req_i = 1'b0;
        tick();
        m1_req_i = 1'b0;
        tick(); tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
